// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache tag/data store with true-LRU replacement
// and a sequencer that streams every dirty line out over a valid/ready port.
module dcache_sram_nway #(
  parameter  int SETS   = 16,
  parameter  int WAYS   = 2,
  parameter  int TAG_W  = 23,
  parameter  int LINE_W = 256,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = $clog2(WAYS),
  localparam int TW     = TAG_W + 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TW-1:0]     tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic [TW-1:0]     tag_o,
  output logic [LINE_W-1:0] data_o,
  output logic              hit_o,
  output logic [WAY_W-1:0]  victim_way_o,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              fl_valid_o,
  input  logic              fl_ready_i,
  output logic [IDX_W-1:0]  fl_set_o,
  output logic [TW-1:0]     fl_tag_o,
  output logic [LINE_W-1:0] fl_data_o,
  output logic              flush_done_o
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t state, state_next;

  logic [TW-1:0]     tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0] data_mem [SETS][WAYS];
  logic [WAY_W-1:0]  age_mem  [SETS][WAYS];

  logic [IDX_W-1:0] scan_set;
  logic [WAY_W-1:0] scan_way;
  logic [TW-1:0]    scan_tag;
  logic             scan_dirty, scan_last;
  logic             start, advance, load_fl, clean_entry;

  logic             any_match, any_invalid;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim_way, sel_way;
  logic             access, do_write, do_touch;

  // Walking ways from the top down lets the lowest matching/invalid index win.
  always_comb begin
    any_match   = 1'b0;
    any_invalid = 1'b0;
    hit_way     = '0;
    inv_way     = '0;
    lru_way     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (tag_mem[addr_i][w][TW-1] &&
          (tag_mem[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0])) begin
        any_match = 1'b1;
        hit_way   = WAY_W'(w);
      end
      if (!tag_mem[addr_i][w][TW-1]) begin
        any_invalid = 1'b1;
        inv_way     = WAY_W'(w);
      end
      if (age_mem[addr_i][w] == WAY_W'(WAYS - 1)) begin
        lru_way = WAY_W'(w);
      end
    end
  end

  assign access       = enable_i & ~busy_o;
  assign hit_o        = access & any_match;
  assign victim_way   = any_invalid ? inv_way : lru_way;
  assign sel_way      = hit_o ? hit_way : victim_way;
  assign do_write     = access & write_i;
  assign do_touch     = hit_o | do_write;
  assign victim_way_o = victim_way;
  assign tag_o        = tag_mem[addr_i][sel_way];
  assign data_o       = data_mem[addr_i][sel_way];

  assign scan_tag   = tag_mem[scan_set][scan_way];
  assign scan_dirty = scan_tag[TW-1] & scan_tag[TAG_W];
  assign scan_last  = (scan_set == IDX_W'(SETS - 1)) && (scan_way == WAY_W'(WAYS - 1));

  // Array storage; CPU accesses and flush cleaning never overlap because
  // accesses are blocked while the walker is busy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[s][w]  <= '0;
          data_mem[s][w] <= '0;
          age_mem[s][w]  <= WAY_W'(w);
        end
      end
    end else begin
      if (do_write) begin
        tag_mem[addr_i][sel_way]  <= tag_i;
        data_mem[addr_i][sel_way] <= data_i;
      end
      if (do_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == sel_way) begin
            age_mem[addr_i][w] <= '0;
          end else if (age_mem[addr_i][w] < age_mem[addr_i][sel_way]) begin
            age_mem[addr_i][w] <= age_mem[addr_i][w] + 1'b1;
          end
        end
      end
      if (clean_entry) begin
        tag_mem[scan_set][scan_way][TAG_W] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (flush_i) state_next = SCAN;
      SCAN: begin
        if (scan_dirty)     state_next = EMIT;
        else if (scan_last) state_next = DONE;
      end
      EMIT: if (fl_ready_i) state_next = scan_last ? DONE : SCAN;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state != IDLE);
    fl_valid_o   = (state == EMIT);
    flush_done_o = (state == DONE);
    start        = (state == IDLE) & flush_i;
    load_fl      = (state == SCAN) & scan_dirty;
    clean_entry  = (state == EMIT) & fl_ready_i;
    advance      = ((state == SCAN) & ~scan_dirty) | clean_entry;
  end

  // Walker position and the registered line presented on the flush port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scan_set  <= '0;
      scan_way  <= '0;
      fl_set_o  <= '0;
      fl_tag_o  <= '0;
      fl_data_o <= '0;
    end else begin
      if (start) begin
        scan_set <= '0;
        scan_way <= '0;
      end else if (advance) begin
        scan_way <= scan_way + 1'b1;
        if (scan_way == WAY_W'(WAYS - 1)) begin
          scan_set <= scan_set + 1'b1;
        end
      end
      if (load_fl) begin
        fl_set_o  <= scan_set;
        fl_tag_o  <= scan_tag;
        fl_data_o <= data_mem[scan_set][scan_way];
      end
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Scoreboard bench: a recency-timestamp reference model predicts every lookup
// and the ordered stream of flushed lines; a negedge monitor checks the DUT.
module tb_dcache_sram_nway;

  localparam int SETS   = 16;
  localparam int WAYS   = 4;
  localparam int TAG_W  = 23;
  localparam int LINE_W = 256;
  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int TW     = TAG_W + 2;

  logic              clk_i, rst_i;
  logic [IDX_W-1:0]  addr_i;
  logic [TW-1:0]     tag_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i, write_i, flush_i, fl_ready_i;
  logic [TW-1:0]     tag_o, fl_tag_o;
  logic [LINE_W-1:0] data_o, fl_data_o;
  logic              hit_o, busy_o, fl_valid_o, flush_done_o;
  logic [WAY_W-1:0]  victim_way_o;
  logic [IDX_W-1:0]  fl_set_o;

  dcache_sram_nway #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
    .enable_i(enable_i), .write_i(write_i), .tag_o(tag_o), .data_o(data_o),
    .hit_o(hit_o), .victim_way_o(victim_way_o), .flush_i(flush_i), .busy_o(busy_o),
    .fl_valid_o(fl_valid_o), .fl_ready_i(fl_ready_i), .fl_set_o(fl_set_o),
    .fl_tag_o(fl_tag_o), .fl_data_o(fl_data_o), .flush_done_o(flush_done_o)
  );

  typedef struct packed {
    logic              hit;
    logic [WAY_W-1:0]  victim;
    logic [TW-1:0]     tag;
    logic [LINE_W-1:0] data;
  } look_t;

  typedef struct packed {
    logic [IDX_W-1:0]  set;
    logic [TW-1:0]     tag;
    logic [LINE_W-1:0] data;
  } line_t;

  look_t look_q[$];
  line_t flush_q[$];

  logic [TW-1:0]     m_tag  [SETS][WAYS];
  logic [LINE_W-1:0] m_data [SETS][WAYS];
  longint            m_use  [SETS][WAYS];
  longint            now_t;

  int n_checks = 0;
  int n_fail   = 0;
  int done_count = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [LINE_W-1:0] act,
                              input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: most recently used way has the largest timestamp.
  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w]  = '0;
        m_data[s][w] = '0;
        m_use[s][w]  = -longint'(w);
      end
    end
    now_t = 0;
  endfunction

  function automatic int m_hit_way(input int s, input logic [TAG_W-1:0] t);
    for (int w = 0; w < WAYS; w++) begin
      if (m_tag[s][w][TW-1] && m_tag[s][w][TAG_W-1:0] == t) return w;
    end
    return -1;
  endfunction

  function automatic int m_victim(input int s);
    int v = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (!m_tag[s][w][TW-1]) return w;
    end
    for (int w = 1; w < WAYS; w++) begin
      if (m_use[s][w] < m_use[s][v]) v = w;
    end
    return v;
  endfunction

  function automatic void build_flush_expect();
    line_t l;
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (m_tag[s][w][TW-1] && m_tag[s][w][TAG_W]) begin
          l.set  = IDX_W'(s);
          l.tag  = m_tag[s][w];
          l.data = m_data[s][w];
          flush_q.push_back(l);
          m_tag[s][w][TAG_W] = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Drives one access at posedge+1, queues its expected response, then
  // advances the model to the post-edge state.
  task automatic apply_stimulus(input int s, input logic [TW-1:0] t,
                                input logic [LINE_W-1:0] d, input logic wr);
    int hw, tw;
    look_t e;
    addr_i = IDX_W'(s); tag_i = t; data_i = d; enable_i = 1'b1; write_i = wr;
    hw = m_hit_way(s, t[TAG_W-1:0]);
    e.hit    = (hw >= 0);
    e.victim = WAY_W'(m_victim(s));
    tw       = (hw >= 0) ? hw : m_victim(s);
    e.tag    = m_tag[s][tw];
    e.data   = m_data[s][tw];
    look_q.push_back(e);
    if (wr) begin
      m_tag[s][tw]  = t;
      m_data[s][tw] = d;
    end
    if (wr || hw >= 0) begin
      now_t++;
      m_use[s][tw] = now_t;
    end
    @(posedge clk_i); #1;
    enable_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic reset_dut();
    enable_i = 1'b0; write_i = 1'b0; flush_i = 1'b0; fl_ready_i = 1'b0;
    rst_i = 1'b1;
    m_reset();
    look_q.delete();
    flush_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  // mode 0: random ready, 1: ready always high, 2: ready low for 5 cycles on first line
  task automatic run_flush(input int mode, input logic with_access);
    int cycles = 0, busy_cnt = 0, low = 0, start_done, n_dirty;
    start_done = done_count;
    fl_ready_i = (mode == 1);
    flush_i = 1'b1;
    if (with_access) apply_stimulus($urandom_range(0, 3), {2'b11, TAG_W'(23'h100 + $urandom_range(0, 6))},
                                    rnd_line(), 1'($urandom_range(0, 1)));
    else begin
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0;
    build_flush_expect();
    n_dirty = flush_q.size();
    while (done_count == start_done && cycles < 3000) begin
      case (mode)
        0:       fl_ready_i = 1'($urandom_range(0, 1));
        1:       fl_ready_i = 1'b1;
        default: fl_ready_i = (low >= 5);
      endcase
      enable_i = 1'($urandom_range(0, 1));
      write_i  = 1'($urandom_range(0, 1));
      flush_i  = 1'($urandom_range(0, 1));
      addr_i   = IDX_W'($urandom_range(0, SETS - 1));
      tag_i    = TW'($urandom());
      data_i   = rnd_line();
      @(negedge clk_i);
      if (busy_o) busy_cnt++;
      if (fl_valid_o && !fl_ready_i) low++;
      @(posedge clk_i); #1;
      cycles++;
    end
    enable_i = 1'b0; write_i = 1'b0; flush_i = 1'b0; fl_ready_i = 1'b0;
    check_output("flush_finished", LINE_W'(done_count - start_done), LINE_W'(1));
    if (mode == 1)
      check_output("flush_length", LINE_W'(busy_cnt), LINE_W'(SETS * WAYS + n_dirty + 1));
    if (mode == 2)
      check_output("ready_low_cycles", LINE_W'(low), LINE_W'(5));
    @(posedge clk_i); #1;
    check_output("single_done_pulse", LINE_W'(done_count - start_done), LINE_W'(1));
    check_output("idle_after_flush", LINE_W'(busy_o), LINE_W'(0));
  endtask

  // Monitor: lookups pop when an unblocked access is presented, flush lines
  // pop on each handshake; a held line must stay valid and unchanged.
  logic              hold = 1'b0;
  logic [IDX_W-1:0]  hold_set;
  logic [TW-1:0]     hold_tag;
  logic [LINE_W-1:0] hold_data;

  always @(negedge clk_i) begin
    look_t le;
    line_t fe;
    if (rst_i) begin
      hold = 1'b0;
    end else begin
      if (enable_i && !busy_o) begin
        check_output("lookup_pending", LINE_W'(look_q.size() != 0), LINE_W'(1));
        if (look_q.size() != 0) begin
          le = look_q.pop_front();
          check_output("hit", LINE_W'(hit_o), LINE_W'(le.hit));
          check_output("victim_way", LINE_W'(victim_way_o), LINE_W'(le.victim));
          check_output("tag_o", LINE_W'(tag_o), LINE_W'(le.tag));
          check_output("data_o", data_o, le.data);
        end
      end
      if (enable_i && busy_o) check_output("hit_while_busy", LINE_W'(hit_o), LINE_W'(0));
      if (hold) begin
        check_output("fl_valid_held", LINE_W'(fl_valid_o), LINE_W'(1));
        check_output("fl_set_stable", LINE_W'(fl_set_o), LINE_W'(hold_set));
        check_output("fl_tag_stable", LINE_W'(fl_tag_o), LINE_W'(hold_tag));
        check_output("fl_data_stable", fl_data_o, hold_data);
      end
      if (fl_valid_o && fl_ready_i) begin
        check_output("flush_pending", LINE_W'(flush_q.size() != 0), LINE_W'(1));
        if (flush_q.size() != 0) begin
          fe = flush_q.pop_front();
          check_output("fl_set", LINE_W'(fl_set_o), LINE_W'(fe.set));
          check_output("fl_tag", LINE_W'(fl_tag_o), LINE_W'(fe.tag));
          check_output("fl_data", fl_data_o, fe.data);
        end
      end
      hold      = fl_valid_o && !fl_ready_i;
      hold_set  = fl_set_o;
      hold_tag  = fl_tag_o;
      hold_data = fl_data_o;
      if (flush_done_o) begin
        done_count++;
        check_output("all_lines_emitted", LINE_W'(flush_q.size()), LINE_W'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LINE_W-1:0] d;
    int cycles, start_done;
    rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; flush_i = 1'b0; fl_ready_i = 1'b0;
    addr_i = '0; tag_i = '0; data_i = '0;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_output("reset_busy", LINE_W'(busy_o), LINE_W'(0));
    check_output("reset_fl_valid", LINE_W'(fl_valid_o), LINE_W'(0));
    check_output("reset_done", LINE_W'(flush_done_o), LINE_W'(0));
    check_output("reset_fl_set", LINE_W'(fl_set_o), LINE_W'(0));
    check_output("reset_fl_tag", LINE_W'(fl_tag_o), LINE_W'(0));
    check_output("reset_fl_data", fl_data_o, LINE_W'(0));
    check_output("reset_victim", LINE_W'(victim_way_o), LINE_W'(0));
    check_output("reset_tag_o", LINE_W'(tag_o), LINE_W'(0));
    @(posedge clk_i); #1;

    $display("[TB] write then read back set 3 tag 0x1A");
    d = rnd_line();
    apply_stimulus(3, {2'b10, TAG_W'(23'h1A)}, d, 1'b1);
    apply_stimulus(3, {2'b10, TAG_W'(23'h1A)}, '0, 1'b0);

    $display("[TB] LRU victim order in a full set");
    for (int t = 1; t <= 4; t++) apply_stimulus(0, {2'b10, TAG_W'(t)}, rnd_line(), 1'b1);
    apply_stimulus(0, {2'b10, TAG_W'(1)}, '0, 1'b0);
    apply_stimulus(0, {2'b10, TAG_W'(3)}, '0, 1'b0);
    for (int t = 5; t <= 8; t++) apply_stimulus(0, {2'b10, TAG_W'(t)}, rnd_line(), 1'b1);

    $display("[TB] flush with back-pressure on the first line");
    reset_dut();
    apply_stimulus(2, {2'b11, TAG_W'(23'h2A)}, rnd_line(), 1'b1);
    apply_stimulus(9, {2'b10, TAG_W'(23'h3B)}, rnd_line(), 1'b1);
    apply_stimulus(9, {2'b11, TAG_W'(23'h3C)}, rnd_line(), 1'b1);
    run_flush(2, 1'b0);
    apply_stimulus(2, {2'b10, TAG_W'(23'h2A)}, '0, 1'b0);
    apply_stimulus(9, {2'b10, TAG_W'(23'h3C)}, '0, 1'b0);

    $display("[TB] randomized accesses with periodic flushes");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3),
                     {1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                      TAG_W'(23'h100 + $urandom_range(0, 6))},
                     rnd_line(), 1'($urandom_range(0, 1)));
      if (i % 100 == 99) run_flush((i == 199) ? 1 : 0, 1'b1);
    end

    $display("[TB] reset while presenting a flush line");
    reset_dut();
    apply_stimulus(1, {2'b11, TAG_W'(23'h55)}, rnd_line(), 1'b1);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    build_flush_expect();
    cycles = 0;
    while (!fl_valid_o && cycles < 200) begin
      @(posedge clk_i); #1;
      cycles++;
    end
    check_output("emit_reached", LINE_W'(fl_valid_o), LINE_W'(1));
    start_done = done_count;
    #2 rst_i = 1'b1;
    #1;
    check_output("async_fl_valid", LINE_W'(fl_valid_o), LINE_W'(0));
    check_output("async_busy", LINE_W'(busy_o), LINE_W'(0));
    check_output("async_fl_set", LINE_W'(fl_set_o), LINE_W'(0));
    m_reset();
    flush_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_output("no_done_after_abort", LINE_W'(done_count), LINE_W'(start_done));
    apply_stimulus(1, {2'b10, TAG_W'(23'h55)}, '0, 1'b0);
    @(posedge clk_i); #1;

    check_output("lookups_drained", LINE_W'(look_q.size()), LINE_W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
